// File: rtl/preamble_inserter_if.sv
//------------------------------------------------------------------------------
// preamble_inserter_if : SC16 AXI-Stream bundle (TDATA/TVALID/TREADY/TLAST)
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface preamble_inserter_if;
  logic [31:0] TDATA;
  logic        TVALID;
  logic        TREADY;
  logic        TLAST;

  modport master (
    output TDATA,
    output TVALID,
    output TLAST,
    input  TREADY
  );

  modport slave (
    input  TDATA,
    input  TVALID,
    input  TLAST,
    output TREADY
  );
endinterface

`default_nettype wire

// File: rtl/preamble_inserter.sv
//------------------------------------------------------------------------------
// preamble_inserter : frames each SC16 packet as [NPER x training symbol][payload][GUARD_LEN zeros]
// Optional macro PREAMBLE_INSERTER_BURST_CNT_EN adds the burst_count output.
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module preamble_inserter #(
  parameter int SYM_LEN = 16,
  parameter int SYM_AW  = 4
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  preamble_inserter_if.slave  i_data,
  preamble_inserter_if.master o_data,
  input  logic [7:0]          NPER,
  input  logic [15:0]         GUARD_LEN,
  input  logic                pre_wr_en,
  input  logic [SYM_AW-1:0]   pre_wr_addr,
  input  logic [31:0]         pre_wr_data,
  output logic                busy
`ifdef PREAMBLE_INSERTER_BURST_CNT_EN
  ,
  output logic [31:0]         burst_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_PAYLOAD  = 2'd2,
    S_GUARD    = 2'd3
  } state_t;

  state_t            r_state;
  logic [31:0]       r_tbl [SYM_LEN];
  logic [SYM_AW-1:0] r_sym_idx;
  logic [7:0]        r_rep_cnt;
  logic [7:0]        r_nper;
  logic [15:0]       r_g_cnt;
  logic [15:0]       r_guard;
  logic [31:0]       r_tdata;
  logic              r_tvalid;
  logic              r_tlast;

  logic              w_adv;
  logic              w_in_rdy;
  logic              w_in_acc;
  logic              w_sym_last;
  logic              w_rep_last;
  logic              w_g_last;
  logic              w_tbl_we;

  assign w_adv      = !r_tvalid || o_data.TREADY;
  assign w_in_rdy   = w_adv && (r_state == S_PAYLOAD);
  assign w_in_acc   = w_in_rdy && i_data.TVALID;
  assign w_sym_last = (r_sym_idx == SYM_AW'(SYM_LEN - 1));
  assign w_rep_last = (r_rep_cnt == (r_nper - 8'd1));
  assign w_g_last   = (r_g_cnt == (r_guard - 16'd1));
  assign w_tbl_we   = pre_wr_en && (r_state == S_IDLE);

  assign i_data.TREADY = w_in_rdy;
  assign o_data.TDATA  = r_tdata;
  assign o_data.TVALID = r_tvalid;
  assign o_data.TLAST  = r_tlast;
  assign busy          = (r_state != S_IDLE);

  // Table writes are only taken while idle so a running burst sees a stable symbol.
  for (genvar gi = 0; gi < SYM_LEN; gi++) begin : g_tbl
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        r_tbl[gi] <= 32'd0;
      end else if (w_tbl_we && (pre_wr_addr == SYM_AW'(gi))) begin
        r_tbl[gi] <= pre_wr_data;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state   <= S_IDLE;
      r_sym_idx <= '0;
      r_rep_cnt <= 8'd0;
      r_nper    <= 8'd0;
      r_g_cnt   <= 16'd0;
      r_guard   <= 16'd0;
      r_tdata   <= 32'd0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_adv) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
          end
          if (i_data.TVALID) begin
            r_nper    <= NPER;
            r_guard   <= GUARD_LEN;
            r_sym_idx <= '0;
            r_rep_cnt <= 8'd0;
            r_g_cnt   <= 16'd0;
            r_state   <= (NPER != 8'd0) ? S_PREAMBLE : S_PAYLOAD;
          end
        end

        S_PREAMBLE: begin
          if (w_adv) begin
            r_tdata   <= r_tbl[r_sym_idx];
            r_tvalid  <= 1'b1;
            r_tlast   <= 1'b0;
            r_sym_idx <= r_sym_idx + 1'b1;
            if (w_sym_last) begin
              r_rep_cnt <= r_rep_cnt + 8'd1;
              if (w_rep_last) begin
                r_state <= S_PAYLOAD;
              end
            end
          end
        end

        S_PAYLOAD: begin
          if (w_adv) begin
            r_tvalid <= i_data.TVALID;
            r_tlast  <= i_data.TLAST && (r_guard == 16'd0);
            if (i_data.TVALID) begin
              r_tdata <= i_data.TDATA;
            end
          end
          if (w_in_acc && i_data.TLAST) begin
            r_state <= (r_guard != 16'd0) ? S_GUARD : S_IDLE;
          end
        end

        S_GUARD: begin
          if (w_adv) begin
            r_tdata  <= 32'd0;
            r_tvalid <= 1'b1;
            r_tlast  <= w_g_last;
            if (w_g_last) begin
              r_g_cnt <= 16'd0;
              r_state <= S_IDLE;
            end else begin
              r_g_cnt <= r_g_cnt + 16'd1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PREAMBLE_INSERTER_BURST_CNT_EN
  logic [31:0] r_burst_cnt;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_burst_cnt <= 32'd0;
    end else if (r_tvalid && r_tlast && o_data.TREADY) begin
      r_burst_cnt <= r_burst_cnt + 32'd1;
    end
  end

  assign burst_count = r_burst_cnt;
`endif

endmodule

`default_nettype wire
